// File: rtl/ad9910_spi_arbiter.sv
// Round-robin arbiter sharing one AD9910 SPI driver between two requesters; readback routed to the owner.
// Define AD9910_AUTO_IOUPD_EN to pulse IO_UPDATE for IOUPD_CYCLES after every successful write.
module ad9910_spi_arbiter #(
    parameter int IOUPD_CYCLES  = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [15:0]  req_instr,
    input  logic [127:0] req_data,
    input  logic [7:0]   req_len,
    output logic [1:0]   rsp_valid,
    output logic [63:0]  rsp_data,
    output logic         rsp_err,
    output logic [1:0]   grant,
    output logic         drv_start,
    output logic [7:0]   drv_instr,
    output logic [63:0]  drv_data,
    output logic [3:0]   drv_len,
    input  logic         drv_busy,
    input  logic [63:0]  drv_rdata,
    output logic         io_update
);

    localparam int CNT_MAX = (IOUPD_CYCLES > START_TIMEOUT) ? IOUPD_CYCLES : START_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
`ifdef AD9910_AUTO_IOUPD_EN
        S_IOUPD,
`endif
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          last_q;
    logic          pick;
    logic          accept;
    logic          load_rsp;
    logic [63:0]   rsp_data_d;
    logic          rsp_err_d;
    logic [63:0]   rd_word;
    logic [7:0]    sel_instr;
    logic [63:0]   sel_data;
    logic [3:0]    sel_len;
    logic          len_ok;

    // On a tie the requester not served last wins; last_q=1 means req1 was served last.
    always_comb begin
        pick      = (req_valid == 2'b11) ? ~last_q : (req_valid[1] & ~req_valid[0]);
        sel_instr = pick ? req_instr[15:8]  : req_instr[7:0];
        sel_data  = pick ? req_data[127:64] : req_data[63:0];
        sel_len   = pick ? req_len[7:4]     : req_len[3:0];
        len_ok    = (sel_len != 4'd0) && (sel_len <= 4'd8);
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        load_rsp   = 1'b0;
        rsp_data_d = 64'd0;
        rsp_err_d  = 1'b0;
        rd_word    = drv_instr[7] ? drv_rdata : 64'd0;
        case (state_q)
            S_IDLE: begin
                // A busy driver here belongs to someone else; wait for it to go idle.
                if (!drv_busy && (|req_valid)) begin
                    accept = 1'b1;
                    if (len_ok) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d   = S_RESP;
                        load_rsp  = 1'b1;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                // cnt_q is 0 on the cycle after drv_start, so RESP lands START_TIMEOUT cycles after it.
                if (drv_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT - 2)) begin
                    state_d   = S_RESP;
                    load_rsp  = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!drv_busy) begin
                    state_d    = S_RESP;
                    load_rsp   = 1'b1;
                    rsp_data_d = rd_word;
`ifdef AD9910_AUTO_IOUPD_EN
                    if (!drv_instr[7]) begin
                        state_d  = S_IOUPD;
                        load_rsp = 1'b0;
                    end
`endif
                end
            end
`ifdef AD9910_AUTO_IOUPD_EN
            S_IOUPD: begin
                // Only writes get here, so the response payload is always zero.
                if (cnt_q == CW'(IOUPD_CYCLES - 1)) begin
                    state_d  = S_RESP;
                    load_rsp = 1'b1;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (accept && !reset) ? (pick ? 2'b10 : 2'b01) : 2'b00;
    assign drv_start = (state_q == S_ISSUE) && !reset;
    assign rsp_valid = (state_q == S_RESP && !reset) ? grant : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            grant     <= 2'b00;
            drv_instr <= 8'd0;
            drv_data  <= 64'd0;
            drv_len   <= 4'd0;
            rsp_data  <= 64'd0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            if (accept) begin
                grant     <= pick ? 2'b10 : 2'b01;
                drv_instr <= sel_instr;
                drv_data  <= sel_data;
                drv_len   <= sel_len;
            end
            if (load_rsp) begin
                rsp_data <= rsp_data_d;
                rsp_err  <= rsp_err_d;
            end
            if (state_q == S_RESP) begin
                last_q <= grant[1];
                grant  <= 2'b00;
            end
        end
    end

`ifdef AD9910_AUTO_IOUPD_EN
    logic io_update_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            io_update_q <= 1'b0;
        end else begin
            io_update_q <= (state_d == S_IOUPD);
        end
    end

    assign io_update = io_update_q & ~reset;
`else
    assign io_update = 1'b0;
`endif

endmodule

// File: tb/tb_ad9910_spi_arbiter.sv
// Directed bench for ad9910_spi_arbiter with a simple SPI driver responder model.
module tb_ad9910_spi_arbiter;

`ifdef AD9910_AUTO_IOUPD_EN
    localparam int EXP_IO = 8;
`else
    localparam int EXP_IO = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [15:0]  req_instr;
    logic [127:0] req_data;
    logic [7:0]   req_len;
    logic [1:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic         rsp_err;
    logic [1:0]   grant;
    logic         drv_start;
    logic [7:0]   drv_instr;
    logic [63:0]  drv_data;
    logic [3:0]   drv_len;
    logic         drv_busy;
    logic [63:0]  drv_rdata;
    logic         io_update;

    ad9910_spi_arbiter #(.IOUPD_CYCLES(8), .START_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_data(req_data), .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .grant(grant),
        .drv_start(drv_start), .drv_instr(drv_instr), .drv_data(drv_data), .drv_len(drv_len),
        .drv_busy(drv_busy), .drv_rdata(drv_rdata), .io_update(io_update)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Monitor state, written only by the negedge monitor.
    int cyc = 0;
    int n_start = 0, start_cyc = 0, io_hi = 0;
    int n_rsp = 0, rsp_cyc = 0, rc0 = 0, rc1 = 0;
    logic [1:0]  last_v = 2'b00;
    logic [63:0] last_d = 64'd0;
    logic        last_e = 1'b0;

    // Driver model controls, written only by the main sequence.
    logic        model_en = 1'b1;
    int          busy_len = 3;
    logic [63:0] model_rdata = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (drv_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
        end
        if (io_update) io_hi <= io_hi + 1;
        if (|rsp_valid) begin
            n_rsp   <= n_rsp + 1;
            rsp_cyc <= cyc;
            rc0     <= rc0 + int'(rsp_valid[0]);
            rc1     <= rc1 + int'(rsp_valid[1]);
            last_v  <= rsp_valid;
            last_d  <= rsp_data;
            last_e  <= rsp_err;
        end
    end

    initial begin
        drv_busy  = 1'b0;
        drv_rdata = 64'd0;
        forever begin
            @(negedge clk);
            if (drv_start && model_en) begin
                @(negedge clk);
                drv_busy  = 1'b1;
                drv_rdata = model_rdata;
                repeat (busy_len) @(negedge clk);
                drv_busy = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int idx, input logic [7:0] ins, input logic [63:0] dat,
                        input logic [3:0] len, input string tag);
        int t;
        int base;
        base = n_rsp;
        @(negedge clk);
        req_instr[idx*8 +: 8]  = ins;
        req_data[idx*64 +: 64] = dat;
        req_len[idx*4 +: 4]    = len;
        req_valid[idx]         = 1'b1;
        #1;
        t = 0;
        while (!req_ready[idx] && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({tag, " accept"}, 64'(t < 100), 64'd1);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        chk({tag, " grant"}, 64'(grant), (idx == 0) ? 64'd1 : 64'd2);
        t = 0;
        while (n_rsp == base && t < 400) begin
            @(posedge clk);
            t++;
        end
        chk({tag, " rsp"}, 64'(t < 400), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int s0, io0, b, r0, r1, t, acc;
        logic [7:0] hist;

        reset     = 1'b1;
        req_valid = 2'b00;
        req_instr = 16'd0;
        req_data  = 128'd0;
        req_len   = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst grant", 64'(grant), 64'd0);
        chk("rst drv_start", 64'(drv_start), 64'd0);
        chk("rst io_update", 64'(io_update), 64'd0);
        chk("rst drv_data", drv_data, 64'd0);
        chk("rst rsp_data", rsp_data, 64'd0);
        chk("rst rsp_err", 64'(rsp_err), 64'd0);

        // T1: req0 write
        s0 = n_start; io0 = io_hi;
        send(0, 8'h0E, 64'h3FFF_0000_1999_999A, 4'd8, "T1");
        chk("T1 starts", 64'(n_start - s0), 64'd1);
        chk("T1 drv_instr", 64'(drv_instr), 64'h0E);
        chk("T1 drv_data", drv_data, 64'h3FFF_0000_1999_999A);
        chk("T1 drv_len", 64'(drv_len), 64'd8);
        chk("T1 rsp_valid", 64'(last_v), 64'd1);
        chk("T1 rsp_err", 64'(last_e), 64'd0);
        chk("T1 io_update cycles", 64'(io_hi - io0), 64'(EXP_IO));
        chk("T1 grant cleared", 64'(grant), 64'd0);

        // T3: req1 read
        io0 = io_hi;
        model_rdata = 64'h0000_0000_0041_0800;
        send(1, 8'h81, 64'd0, 4'd4, "T3");
        chk("T3 rsp_valid", 64'(last_v), 64'd2);
        chk("T3 rsp_data", last_d, 64'h410800);
        chk("T3 rsp_err", 64'(last_e), 64'd0);
        chk("T3 io_update", 64'(io_hi - io0), 64'd0);
        chk("T3 drv_len", 64'(drv_len), 64'd4);

        // T2: both requesters held valid for 4 transactions
        b = n_rsp; r0 = rc0; r1 = rc1;
        @(negedge clk);
        req_instr = 16'h0B0A;
        req_data  = {64'h2222, 64'h1111};
        req_len   = 8'h11;
        req_valid = 2'b11;
        acc = 0; hist = 8'd0; t = 0;
        while (acc < 4 && t < 400) begin
            #1;
            if (|req_ready) begin
                hist = {hist[5:0], req_ready};
                acc++;
            end
            @(negedge clk);
            t++;
        end
        req_valid = 2'b00;
        t = 0;
        while (n_rsp - b < 4 && t < 400) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("T2 grant order", 64'(hist), 64'b01_10_01_10);
        chk("T2 req0 rsps", 64'(rc0 - r0), 64'd2);
        chk("T2 req1 rsps", 64'(rc1 - r1), 64'd2);

        // T4: driver never goes busy
        model_en = 1'b0;
        send(0, 8'h0E, 64'h55, 4'd2, "T4");
        chk("T4 rsp_err", 64'(last_e), 64'd1);
        chk("T4 timeout cycles", 64'(rsp_cyc - start_cyc), 64'd16);
        model_en = 1'b1;
        model_rdata = 64'hDEAD_BEEF;
        send(1, 8'h80, 64'd0, 4'd4, "T4b");
        chk("T4b rsp_valid", 64'(last_v), 64'd2);
        chk("T4b rsp_err", 64'(last_e), 64'd0);
        chk("T4b rsp_data", last_d, 64'hDEAD_BEEF);

        // T5: illegal lengths
        s0 = n_start;
        send(0, 8'h0E, 64'h1, 4'd0, "T5a");
        chk("T5a starts", 64'(n_start - s0), 64'd0);
        chk("T5a rsp_valid", 64'(last_v), 64'd1);
        chk("T5a rsp_err", 64'(last_e), 64'd1);
        chk("T5a rsp_data", last_d, 64'd0);
        send(1, 8'h81, 64'h1, 4'd9, "T5b");
        chk("T5b starts", 64'(n_start - s0), 64'd0);
        chk("T5b rsp_valid", 64'(last_v), 64'd2);
        chk("T5b rsp_err", 64'(last_e), 64'd1);
        chk("T5b rsp_data", last_d, 64'd0);

        // T6: reset in the middle of a transaction
        busy_len = (EXP_IO != 0) ? 2 : 20;
        b = n_rsp;
        @(negedge clk);
        req_instr[7:0] = 8'h0E;
        req_data[63:0] = 64'h77;
        req_len[3:0]   = 4'd4;
        req_valid[0]   = 1'b1;
        #1;
        t = 0;
        while (!req_ready[0] && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        t = 0;
`ifdef AD9910_AUTO_IOUPD_EN
        while (!io_update && t < 100) begin
`else
        while (!drv_busy && t < 100) begin
`endif
            @(negedge clk);
            t++;
        end
        chk("T6 reached target state", 64'(t < 100), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("T6 io_update", 64'(io_update), 64'd0);
        chk("T6 grant", 64'(grant), 64'd0);
        chk("T6 rsp_valid", 64'(rsp_valid), 64'd0);
        chk("T6 drv_start", 64'(drv_start), 64'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("T6 no rsp after abort", 64'(n_rsp - b), 64'd0);
        busy_len = 3;
        io0 = io_hi;
        send(0, 8'h0E, 64'h1234, 4'd2, "T6b");
        chk("T6b rsp_valid", 64'(last_v), 64'd1);
        chk("T6b rsp_err", 64'(last_e), 64'd0);
        chk("T6b io_update cycles", 64'(io_hi - io0), 64'(EXP_IO));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
